// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: folds 0xE0/0xF0 prefixes into single key events
// and queues them in a first-word-fall-through FIFO that throttles the receiver.
module ps2_scancode_decoder #(
  parameter int ADDR_W = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  input  logic       rd_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_evt_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t            state;
  key_evt_t          mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;

  logic is_e0, is_f0, emit, pend_ext, pend_rel, push, pop, drop;
  key_evt_t head;

  assign is_e0    = (rx_data == 8'hE0);
  assign is_f0    = (rx_data == 8'hF0);
  assign emit     = rx_done_tick && !is_e0 && !is_f0;
  assign pend_ext = (state == EXT) || (state == EXT_BRK);
  assign pend_rel = (state == BRK) || (state == EXT_BRK);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees the slot this cycle, so push-while-full with a pop still lands.
  assign pop  = rd_en && !empty;
  assign push = emit && (!full || pop);
  assign drop = emit && full && !pop;

  assign head     = mem[rd_ptr];
  assign key_code = head.code;
  assign key_ext  = head.ext;
  assign key_rel  = head.rel;

  // Prefix tracker; any non-prefix byte (emitted or dropped) returns to IDLE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else if (rx_done_tick) begin
      case (state)
        IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
        EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
        BRK:     state <= is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
        EXT_BRK: state <= (is_e0 || is_f0) ? EXT_BRK : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rx_enable <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{code: rx_data, ext: pend_ext, rel: pend_rel};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      rx_enable <= ~full;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed plus randomized checks of ps2_scancode_decoder against a
// prefix-flag/queue reference model.
module tb_ps2_scancode_decoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_enable;
  logic       rd_en = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_rel, empty, full, overflow;

  ps2_scancode_decoder #(.ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_enable(rx_enable), .rd_en(rd_en), .key_code(key_code), .key_ext(key_ext),
    .key_rel(key_rel), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference model: pending prefix flags and a queue of {code, ext, rel}.
  logic [9:0] q[$];
  logic ext_p, rel_p, ovf_m, rxen_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ext_p = 0; rel_p = 0; ovf_m = 0; rxen_m = 1;
  endtask

  task automatic model_edge(input logic t, input logic [7:0] d, input logic rd);
    logic popm, pushm;
    logic [9:0] ev;
    rxen_m = (q.size() != DEPTH);
    popm   = rd && (q.size() > 0);
    pushm  = 0;
    ev     = '0;
    if (t) begin
      if (d == 8'hE0) ext_p = 1;
      else if (d == 8'hF0) rel_p = 1;
      else begin
        ev = {d, ext_p, rel_p};
        ext_p = 0; rel_p = 0;
        if (q.size() < DEPTH || popm) pushm = 1;
        else ovf_m = 1;
      end
    end
    if (popm) void'(q.pop_front());
    if (pushm) q.push_back(ev);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    chk({tag, ".rx_enable"}, 32'(rx_enable), 32'(rxen_m));
    if (q.size() > 0)
      chk({tag, ".head"}, {22'b0, key_code, key_ext, key_rel}, {22'b0, q[0]});
  endtask

  task automatic step(input string tag, input logic t, input logic [7:0] d, input logic rd);
    @(negedge Clock);
    rx_done_tick = t; rx_data = d; rd_en = rd;
    @(posedge Clock);
    model_edge(t, d, rd);
    #1;
    check_all(tag);
    rx_done_tick = 0; rd_en = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".rx_enable"}, 32'(rx_enable), 32'd1);
    chk({tag, ".key"}, {22'b0, key_code, key_ext, key_rel}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    Reset = 0; rx_done_tick = 0; rd_en = 0;
    #1;
    model_reset();
    check_reset_vals({tag, ".async"});
    @(negedge Clock);
    check_reset_vals({tag, ".held"});
    Reset = 1;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // Read while empty
    step("rd_empty", 0, 8'h00, 1);
    chk("rd_empty.code", 32'(key_code), 32'h00);
    chk("rd_empty.empty", 32'(empty), 32'd1);

    // Make / break
    step("mb1", 1, 8'h1C, 0);
    chk("mb1.visible", 32'(empty), 32'd0);
    step("mb2", 1, 8'hF0, 0);
    step("mb3", 1, 8'h1C, 0);
    chk("mb.head", {22'b0, key_code, key_ext, key_rel}, {22'b0, 8'h1C, 2'b00});
    step("mb.pop1", 0, 8'h00, 1);
    chk("mb.second", {22'b0, key_code, key_ext, key_rel}, {22'b0, 8'h1C, 2'b01});
    step("mb.pop2", 0, 8'h00, 1);

    // Extended release
    step("er1", 1, 8'hE0, 0);
    chk("er1.noentry", 32'(empty), 32'd1);
    step("er2", 1, 8'hF0, 0);
    step("er3", 1, 8'h75, 0);
    chk("er.head", {22'b0, key_code, key_ext, key_rel}, {22'b0, 8'h75, 2'b11});
    step("er.pop", 0, 8'h00, 1);

    // Fill, overflow, drain
    step("f1", 1, 8'h15, 0);
    step("f2", 1, 8'h1D, 0);
    step("f3", 1, 8'h24, 0);
    step("f4", 1, 8'h2D, 0);
    chk("f4.full", 32'(full), 32'd1);
    chk("f4.rxen_lag", 32'(rx_enable), 32'd1);
    step("f5", 1, 8'h2C, 0);
    chk("f5.rxen", 32'(rx_enable), 32'd0);
    chk("f5.ovf", 32'(overflow), 32'd1);
    step("d1", 0, 8'h00, 1);
    step("d2", 0, 8'h00, 1);
    step("d3", 0, 8'h00, 1);
    chk("d3.head", 32'(key_code), 32'h2D);
    step("d4", 0, 8'h00, 1);
    chk("d4.empty", 32'(empty), 32'd1);

    // Simultaneous push/pop while full
    do_reset("rst1");
    step("s1", 1, 8'h15, 0);
    step("s2", 1, 8'h1D, 0);
    step("s3", 1, 8'h24, 0);
    step("s4", 1, 8'h2D, 0);
    step("s5", 1, 8'h33, 1);
    chk("s5.head", 32'(key_code), 32'h1D);
    chk("s5.full", 32'(full), 32'd1);
    chk("s5.ovf", 32'(overflow), 32'd0);
    step("s.p1", 0, 8'h00, 1);
    step("s.p2", 0, 8'h00, 1);
    step("s.p3", 0, 8'h00, 1);
    chk("s.tail", {22'b0, key_code, key_ext, key_rel}, {22'b0, 8'h33, 2'b00});
    step("s.p4", 0, 8'h00, 1);

    // Reset mid-prefix
    step("rm1", 1, 8'hF0, 0);
    do_reset("rst2");
    step("rm2", 1, 8'h1C, 0);
    chk("rm2.head", {22'b0, key_code, key_ext, key_rel}, {22'b0, 8'h1C, 2'b00});

    // Randomized traffic, prefix-heavy
    for (int i = 0; i < 2000; i++) begin
      logic t, rd;
      logic [7:0] d;
      int sel;
      t   = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 35);
      sel = $urandom_range(0, 7);
      d   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
      step("rand", t, d, rd);
      if (i == 1000) do_reset("rst_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream of the PS/2 receive stage. Consumes each received byte, flagged by a one-cycle done tick, and decodes set-2 prefixes (0xE0 extended, 0xF0 break) into single key events: 8-bit code, extended flag and release flag.
- Events are buffered in a small first-word-fall-through FIFO for the consumer logic (display/control FSM).
- Drives the receiver's rx_enable so no new frame starts while the FIFO is full.

Parameters:
ADDR_W, 2, FIFO address width; depth = 2**ADDR_W entries (ADDR_W >= 1)

Ports:
Clock  input  1  system clock; all state updates on its rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_done_tick  input  1  one-cycle pulse: rx_data holds a new byte this cycle
rx_data  input  8  byte from receive stage
rx_enable  output  1  to receive stage; 1 = a new frame may start
rd_en  input  1  consumer pops the head entry at this edge
key_code  output  8  head entry scan code (valid when empty = 0)
key_ext  output  1  head entry had 0xE0 prefix
key_rel  output  1  head entry had 0xF0 prefix (break)
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds 2**ADDR_W entries
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (Reset = 0, async):
  - Decoder state = IDLE; FIFO pointers and count = 0.
  - Outputs: empty = 1, full = 0, overflow = 0, rx_enable = 1.
  - key_code = 0x00, key_ext = 0, key_rel = 0; all storage entries cleared.
- Decoder FSM advances only in cycles where rx_done_tick = 1. Other cycles hold state.
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - Any other byte -> emit {byte, ext=0, rel=0}; stay IDLE.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 -> stay EXT (redundant prefix absorbed).
    - Other byte -> emit {byte, 1, 0}; go to IDLE.
  - BRK:
    - 0xF0 -> stay BRK.
    - 0xE0 -> EXT_BRK.
    - Other byte -> emit {byte, 0, 1}; go to IDLE.
  - EXT_BRK:
    - 0xE0 or 0xF0 -> stay EXT_BRK.
    - Other byte -> emit {byte, 1, 1}; go to IDLE.
  - 0xE1 (pause) sequences are not specially handled; 0xE1 is an ordinary code.
- Emit = FIFO push at the same rising edge that samples rx_done_tick.
  - The entry is visible on key_* and empty drops to 0 in the next cycle (1-cycle latency tick -> visible).
  - Prefix bytes never push.
- FIFO is first-word-fall-through: key_code, key_ext and key_rel always reflect the oldest entry.
  - Pop on rd_en = 1 with empty = 0; the next entry (or empty = 1) is visible the following cycle.
  - rd_en while empty is ignored. Pointers wrap modulo 2**ADDR_W.
  - Count is ADDR_W+1 bits. full = (count == 2**ADDR_W); empty = (count == 0).
- Simultaneous push and pop:
  - When not empty: both occur and count is unchanged. This includes the full case, where no drop occurs and overflow is not set.
  - When empty: the pop is ignored and the push succeeds.
- Push while full without a pop: the event is dropped, overflow is set to 1, and the FIFO contents are unchanged.
  - overflow clears only on reset.
  - The FSM still returns to IDLE, so the dropped event does not corrupt prefix tracking.
- rx_enable = ~full, registered: it updates the cycle after count changes.
  - A frame already in flight when full rises can still deliver a tick; that case is covered by the overflow rule.
- Reset asserted mid-sequence (e.g. after 0xF0) discards the pending prefix. The first byte after reset is decoded from IDLE.

Test Plan:
- Make/break: ticks 0x1C, then 0xF0, 0x1C.
  - Expect two entries: {1C,0,0} and {1C,0,1}.
  - empty = 0 one cycle after the first tick.
- Extended release: ticks 0xE0, 0xF0, 0x75.
  - Expect a single entry {75,1,1}; no entry for either prefix byte.
- Full and overflow (ADDR_W = 2): push 5 make codes 0x15, 0x1D, 0x24, 0x2D, 0x2C without reading.
  - full = 1 after the 4th; rx_enable = 0 the cycle after.
  - 5th is dropped and overflow = 1.
  - Pops then return 15, 1D, 24, 2D and empty = 1.
- Simultaneous push and pop when full: push 0x33 with rd_en = 1.
  - Head advances, 0x33 lands at the tail, count stays 4, overflow stays 0.
- Reset mid-prefix: tick 0xF0, pulse Reset low for 1 cycle, then tick 0x1C.
  - Entry {1C,0,0}; all outputs held at reset values during reset.
- Read while empty: rd_en = 1 with no entries.
  - No state change; empty stays 1; key_code stays 0x00.
